// File: rtl/dispense_pkg.sv
// Shared state encodings and default sizing for the dispense actuator controller.
package dispense_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RUN   = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_DONE  = 3'd3;
  localparam state_t S_FAULT = 3'd4;

  localparam int MOTOR_CYCLES_DEF = 8;
  localparam int TIMEOUT_DEF      = 32;
  localparam int CW_DEF           = 6;

endpackage

// File: rtl/dispense_timer.sv
// Cycle counter with synchronous clear, count enable and terminal-value compare.
module dispense_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic          at_term
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en)
      count <= count + CW'(1);
  end

  assign at_term = (count == term);

endmodule

// File: rtl/dispense_unit.sv
// Dispense actuator controller: runs the motor for a fixed time, then waits for the
// drop sensor and reports completion or a jam/timeout fault.
module dispense_unit
  import dispense_pkg::*;
#(
  parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic FD,
  input  logic DROP,
  input  logic CLR,
  output logic MOTOR,
  output logic BUSY,
  output logic DONE,
  output logic FAULT
);

  localparam logic [CW-1:0] RUN_TERM  = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_TERM = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic          fd_q;
  logic          drop_seen;
  logic          req;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_at;
  logic [CW-1:0] tmr_term;

  assign req = FD & ~fd_q;

  // One timer serves both phases; the terminal value follows the current state.
  assign tmr_term = (state == S_RUN) ? RUN_TERM : WAIT_TERM;

  dispense_timer #(.CW(CW)) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .at_term (tmr_at)
  );

  always_comb begin
    state_nx = state;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nx = S_RUN;
          tmr_clr  = 1'b1;
        end
      end
      S_RUN: begin
        if (tmr_at) begin
          tmr_clr  = 1'b1;
          state_nx = (drop_seen || DROP) ? S_DONE : S_WAIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_WAIT: begin
        // A drop on the timeout cycle still counts as a successful dispense.
        if (DROP)
          state_nx = S_DONE;
        else if (tmr_at)
          state_nx = S_FAULT;
        else
          tmr_en = 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      S_FAULT: begin
        if (CLR)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      fd_q      <= 1'b0;
      drop_seen <= 1'b0;
    end else begin
      state <= state_nx;
      fd_q  <= FD;
      if (state == S_IDLE && req)
        drop_seen <= 1'b0;
      else if (state == S_RUN && DROP)
        drop_seen <= 1'b1;
    end
  end

  assign MOTOR = (state == S_RUN);
  assign BUSY  = (state == S_RUN) || (state == S_WAIT);
  assign DONE  = (state == S_DONE);
  assign FAULT = (state == S_FAULT);

endmodule

// File: tb/tb_dispense_unit.sv
// Scoreboard bench for dispense_unit with MOTOR_CYCLES=4, TIMEOUT=6.
module tb_dispense_unit;

  localparam int MC = 4;
  localparam int TO = 6;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst, fd, drop, clr;
  logic motor, busy, done, fault;

  dispense_unit #(.MOTOR_CYCLES(MC), .TIMEOUT(TO), .CW(CW)) dut (
    .CLK   (clk),
    .RST   (rst),
    .FD    (fd),
    .DROP  (drop),
    .CLR   (clr),
    .MOTOR (motor),
    .BUSY  (busy),
    .DONE  (done),
    .FAULT (fault)
  );

  always #5 clk = ~clk;

  // Expected {MOTOR,BUSY,DONE,FAULT} per cycle, and expected completion events in order.
  logic [3:0] exp_q[$];
  string      tag_q[$];
  byte        ev_q[$];
  int         checks = 0;
  int         errors = 0;
  string      scen = "reset";

  logic [3:0] m_exp;
  string      m_tag;
  byte        m_want;
  byte        m_got;
  logic       fault_prev = 1'b0;

  task automatic cyc(input logic f, input logic d, input logic c, input logic r,
                     input logic [3:0] e);
    fd   = f;
    drop = d;
    clr  = c;
    rst  = r;
    exp_q.push_back(e);
    tag_q.push_back(scen);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs mid-cycle and matches DONE/FAULT events against the event queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      checks++;
      if ({motor, busy, done, fault} !== m_exp) begin
        errors++;
        $display("FAIL %s: MBDF got %b want %b at %0t", m_tag, {motor, busy, done, fault}, m_exp, $time);
      end
    end
    if (done === 1'b1 || (fault === 1'b1 && fault_prev !== 1'b1)) begin
      m_want = (done === 1'b1) ? "D" : "F";
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL %s_event: got %c want none at %0t", scen, m_want, $time);
      end else begin
        m_got = ev_q.pop_front();
        if (m_got !== m_want) begin
          errors++;
          $display("FAIL %s_event: got %c want %c at %0t", scen, m_want, m_got, $time);
        end
      end
    end
    fault_prev = fault;
  end

  initial begin
    rst = 1'b1; fd = 1'b0; drop = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 1, 4'b0000);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "drop_in_wait";
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    repeat (MC) cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 0, 0, 0, 4'b0100);
    cyc(1, 0, 0, 0, 4'b0100);
    cyc(1, 1, 0, 0, 4'b0100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "early_drop";
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 1, 0, 0, 4'b1100);
    cyc(1, 0, 1, 0, 4'b1100);
    cyc(1, 0, 0, 0, 4'b1100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "timeout_clear";
    ev_q.push_back("F");
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    repeat (MC) cyc(1, 0, 0, 0, 4'b1100);
    repeat (TO) cyc(1, 0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 0, 4'b0001);
    cyc(1, 0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 0, 4'b0001);
    cyc(0, 0, 1, 0, 4'b0001);
    cyc(0, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 1, 0, 0, 4'b1100);
    repeat (MC - 1) cyc(1, 0, 0, 0, 4'b1100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "level_fd";
    ev_q.push_back("D");
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    repeat (MC) cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 1, 0, 0, 4'b0100);
    cyc(1, 0, 0, 0, 4'b0010);
    repeat (13) cyc(1, 0, 0, 0, 4'b0000);
    cyc(0, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b0000);
    repeat (MC - 1) cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 1, 0, 0, 4'b1100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "reset_mid_run";
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 0, 0, 0, 4'b1100);
    cyc(1, 0, 0, 1, 4'b1100);
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 1, 0, 0, 4'b1100);
    repeat (MC - 1) cyc(1, 0, 0, 0, 4'b1100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);

    scen = "drop_at_timeout";
    ev_q.push_back("D");
    cyc(1, 0, 0, 0, 4'b0000);
    repeat (MC) cyc(1, 0, 0, 0, 4'b1100);
    repeat (TO - 1) cyc(1, 0, 0, 0, 4'b0100);
    cyc(1, 1, 0, 0, 4'b0100);
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0, 4'b0000);
    cyc(0, 0, 0, 0, 4'b0000);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d cycles and %0d events left want 0 and 0", exp_q.size(), ev_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
